// File: rtl/uart_rx_stamper.sv
// Oversampled UART receiver that tags each byte with the timestamp
// present at its start-bit falling edge, behind a one-deep output register.
module uart_rx_stamper #(
    parameter int unsigned BAUD_DIV   = 27,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rx,
    input  logic [3:0]  acqurate_stamp,
    input  logic [11:0] millisecond_stamp,
    input  logic [31:0] second_stamp,
    output logic [7:0]  rx_data,
    output logic [47:0] rx_stamp,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overrun
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]  state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [15:0] div_cnt;
    logic [3:0]  phase;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [47:0] stamp;
    logic        par_bad;

    logic tick;
    logic centre;
    logic mid_start;
    logic start_det;
    logic done;

    assign tick      = (state != IDLE) && (div_cnt == 16'(BAUD_DIV - 1));
    assign centre    = tick && (phase == 4'd15);
    assign mid_start = tick && (phase == 4'd7);
    assign start_det = (state == IDLE) && rx_prev && !rx_sync;
    assign done      = (state == STOP) && centre;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Phase realigns to the start-bit centre so data samples land mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (start_det) begin
            div_cnt <= '0;
            phase   <= '0;
        end else if (state != IDLE) begin
            if (tick) begin
                div_cnt <= '0;
                phase   <= (state == START && phase == 4'd7) ?
                           4'd0 : phase + 4'd1;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            stamp   <= '0;
            par_bad <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start_det) begin
                    state   <= START;
                    par_bad <= 1'b0;
                    stamp   <= {second_stamp, millisecond_stamp,
                                acqurate_stamp};
                end
                START: if (mid_start) begin
                    bit_cnt <= '0;
                    state   <= rx_sync ? IDLE : DATA;
                end
                DATA: if (centre) begin
                    shift   <= {rx_sync, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= PARITY_EN ? PARITY : STOP;
                end
                PARITY: if (centre) begin
                    par_bad <= ((^shift) ^ rx_sync) != PARITY_ODD;
                    state   <= STOP;
                end
                STOP: if (centre) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_stamp   <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift;
                    rx_stamp   <= stamp;
                    frame_err  <= !rx_sync;
                    parity_err <= par_bad;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_stamper.sv
// Bench for uart_rx_stamper: an 8N1 instance checked against a byte queue
// every cycle, plus an even-parity instance on its own serial line.
module tb_uart_rx_stamper;

    localparam int BD   = 4;
    localparam int BITC = 16 * BD;

    typedef struct packed {
        logic [7:0]  d;
        logic [47:0] s;
        logic        fe;
        logic        pe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_a = 1'b1;
    logic        rx_b = 1'b1;
    logic        rdy_a = 1'b1;
    logic        rdy_b = 1'b1;
    logic [3:0]  acq = '0;
    logic [11:0] ms = '0;
    logic [31:0] sec = '0;

    logic [7:0]  rx_data, b_rx_data;
    logic [47:0] rx_stamp, b_rx_stamp;
    logic        rx_valid, b_rx_valid;
    logic        frame_err, b_frame_err;
    logic        parity_err, b_parity_err;
    logic        overrun, b_overrun;

    int total = 0;
    int bad = 0;

    exp_t        exp_q[$];
    logic [7:0]  last_data = '0;
    logic [47:0] last_stamp = '0;
    logic        last_fe = 1'b0;
    logic        last_pe = 1'b0;
    int          run = 0;
    int          last_run = 0;
    int          delivered = 0;
    int          ovr_seen = 0;
    logic        prev_ovr = 1'b0;

    int          b_cnt = 0;
    logic [7:0]  b_data = '0;
    logic        b_fe = 1'b0;
    logic        b_pe = 1'b0;

    always #5 clk = ~clk;

    uart_rx_stamper #(
        .BAUD_DIV(BD), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .Rx(rx_a),
        .acqurate_stamp(acq), .millisecond_stamp(ms),
        .second_stamp(sec),
        .rx_data(rx_data), .rx_stamp(rx_stamp),
        .rx_valid(rx_valid), .rx_ready(rdy_a),
        .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun)
    );

    uart_rx_stamper #(
        .BAUD_DIV(BD), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
    ) u_par (
        .clk(clk), .rst(rst), .Rx(rx_b),
        .acqurate_stamp(acq), .millisecond_stamp(ms),
        .second_stamp(sec),
        .rx_data(b_rx_data), .rx_stamp(b_rx_stamp),
        .rx_valid(b_rx_valid), .rx_ready(rdy_b),
        .frame_err(b_frame_err), .parity_err(b_parity_err),
        .overrun(b_overrun)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Every cycle: outputs zero in reset, else held byte matches queue head.
    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_outputs",
                {rx_valid, frame_err, parity_err, overrun, rx_data, rx_stamp},
                64'd0);
            run = 0;
            prev_ovr = 1'b0;
        end else begin
            if (rx_valid) begin
                run++;
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 64'(rx_valid), 64'd0);
                end else begin
                    chk("byte",
                        {rx_data, rx_stamp, frame_err, parity_err},
                        {exp_q[0].d, exp_q[0].s, exp_q[0].fe, exp_q[0].pe});
                    if (rdy_a) begin
                        last_data  = rx_data;
                        last_stamp = rx_stamp;
                        last_fe    = frame_err;
                        last_pe    = parity_err;
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end else if (run > 0) begin
                last_run = run;
                run = 0;
            end
            if (overrun) begin
                ovr_seen++;
                chk("overrun_width", 64'(prev_ovr), 64'd0);
            end
            prev_ovr = overrun;
        end
    end

    always @(negedge clk) begin
        if (rst && b_rx_valid) begin
            b_cnt++;
            b_data = b_rx_data;
            b_fe   = b_frame_err;
            b_pe   = b_parity_err;
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input bit line, input logic v);
        if (line) rx_b = v;
        else      rx_a = v;
    endtask

    task automatic send(input bit line, input logic [7:0] d,
                        input logic stop, input bit use_par,
                        input logic pbit, input bit push);
        exp_t e;
        if (!line && push) begin
            e.d  = d;
            e.s  = {sec, ms, acq};
            e.fe = ~stop;
            e.pe = 1'b0;
            exp_q.push_back(e);
        end
        set_rx(line, 1'b0);
        hold(BITC);
        // Stamps move on mid-frame; the byte must keep the start-edge value.
        sec = sec + 32'd1;
        ms  = ms + 12'd3;
        acq = acq + 4'd5;
        for (int i = 0; i < 8; i++) begin
            set_rx(line, d[i]);
            hold(BITC);
        end
        if (use_par) begin
            set_rx(line, pbit);
            hold(BITC);
        end
        set_rx(line, stop);
        hold(BITC);
        set_rx(line, 1'b1);
        hold(BITC);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n0;
        int o0;
        #2 rst = 1'b0;
        hold(5);
        rst = 1'b1;
        hold(10);

        sec = 32'h12;
        ms  = 12'h3E8;
        acq = 4'h7;
        send(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        drain("drain_a5");
        hold(3);
        chk("a5_data", 64'(last_data), 64'hA5);
        chk("a5_stamp", 64'(last_stamp), 64'h000000123E87);
        chk("a5_flags", 64'({last_fe, last_pe}), 64'd0);
        chk("a5_valid_cycles", 64'(last_run), 64'd1);

        n0 = delivered;
        rx_a = 1'b0;
        hold(20);
        rx_a = 1'b1;
        hold(100);
        chk("glitch_no_byte", 64'(delivered - n0), 64'd0);
        send(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        drain("drain_3c");
        chk("3c_data", 64'(last_data), 64'h3C);

        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        drain("drain_55");
        chk("55_data", 64'(last_data), 64'h55);
        chk("55_frame_err", 64'(last_fe), 64'd1);

        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(2);
        chk("par_bad_count", 64'(b_cnt), 64'd1);
        chk("par_bad_data", 64'(b_data), 64'h07);
        chk("par_bad_flag", 64'(b_pe), 64'd1);
        chk("par_bad_frame", 64'(b_fe), 64'd0);
        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(2);
        chk("par_ok_count", 64'(b_cnt), 64'd2);
        chk("par_ok_flag", 64'(b_pe), 64'd0);

        rdy_a = 1'b0;
        send(1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        o0 = ovr_seen;
        send(1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulses", 64'(ovr_seen - o0), 64'd1);
        chk("held_data", 64'(rx_data), 64'h11);
        chk("held_valid", 64'(rx_valid), 64'd1);
        rdy_a = 1'b1;
        hold(1);
        chk("valid_drop", 64'(rx_valid), 64'd0);
        drain("drain_11");

        n0 = delivered;
        rx_a = 1'b0;
        hold(BITC);
        for (int i = 0; i < 4; i++) begin
            rx_a = (i == 0);
            hold(BITC);
        end
        rx_a = 1'b0;
        hold(30);
        rst  = 1'b0;
        rx_a = 1'b1;
        hold(10);
        rst = 1'b1;
        hold(BITC);
        chk("abort_no_byte", 64'(delivered - n0), 64'd0);
        send(1'b0, 8'h42, 1'b1, 1'b0, 1'b0, 1'b1);
        drain("drain_42");
        chk("42_data", 64'(last_data), 64'h42);
        chk("abort_count", 64'(delivered - n0), 64'd1);

        chk("total_overruns", 64'(ovr_seen), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_stamper.md
UART_RX_STAMPER -- requirements
Module: uart_rx_stamper

Interface
REQ-001 Parameter BAUD_DIV, default 27: clk cycles per oversample tick; 16 ticks per bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts a parity bit between D7 and stop.
REQ-003 Parameter PARITY_ODD, default 0: 1 selects odd parity, 0 even; ignored when PARITY_EN=0.
REQ-004 Clocking: one clock, clk; reset rst is asynchronous and active-low.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  async active-low reset.
REQ-007 Rx  input  1  serial line, idle high, asynchronous to clk.
REQ-008 acqurate_stamp  input  4  sub-millisecond time count.
REQ-009 millisecond_stamp  input  12  millisecond count.
REQ-010 second_stamp  input  32  second count.
REQ-011 rx_data  output  8  received byte, LSB first on line.
REQ-012 rx_stamp  output  48  {second, millisecond, acqurate} at start-bit falling edge.
REQ-013 rx_valid  output  1  rx_data/rx_stamp/flags hold a byte.
REQ-014 rx_ready  input  1  consumer accepts byte.
REQ-015 frame_err  output  1  stop bit sampled low for held byte.
REQ-016 parity_err  output  1  parity mismatch for held byte; 0 when PARITY_EN=0.
REQ-017 overrun  output  1  one-cycle pulse: completed byte dropped.

Function
REQ-018 Rx passes a 2-flop synchronizer, reset value 1; all decisions use the synchronized value.
REQ-019 Tick counter runs only outside IDLE, restarts at 0 on start detection, emits tick every BAUD_DIV clk.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE: synchronized Rx 1->0 -> START; stamp inputs captured same cycle into a 48-bit stamp register.
REQ-022 START: at tick 8, Rx=1 -> IDLE (glitch, no output, no flags); Rx=0 -> DATA with 16-tick phase counter cleared.
REQ-023 DATA: sample Rx every 16 ticks (bit centre), shift in LSB first; after 8th sample -> PARITY if PARITY_EN else STOP.
REQ-024 PARITY: sample at next bit centre; error when XOR(data,parity bit) != PARITY_ODD.
REQ-025 STOP: sample at bit centre; Rx=0 sets frame error; byte completes this cycle; -> IDLE same cycle (next start detectable from the following clk).
REQ-026 Byte delivered even with frame or parity error.
REQ-027 Output register: on completion with rx_valid=0, or rx_valid=1 and rx_ready=1 same cycle, load data/stamp/flags, rx_valid=1 next cycle.
REQ-028 Completion with rx_valid=1 and rx_ready=0: new byte discarded, held byte unchanged, overrun=1 for exactly one cycle.
REQ-029 rx_valid drops the cycle after rx_valid&&rx_ready with no new completion.
REQ-030 Outputs stable while rx_valid=1 and rx_ready=0.
REQ-031 Latency: rx_valid rises 1 clk after stop-bit centre sample.

Reset
REQ-032 rst low: FSM IDLE, counters 0, synchronizer 1, rx_data 0, rx_stamp 0, rx_valid 0, frame_err 0, parity_err 0, overrun 0.
REQ-033 rst low mid-frame aborts frame; no byte delivered after release; next falling edge starts fresh frame.

Verification
REQ-034 BAUD_DIV=4, rx_ready=1, send 0xA5 8N1, stamp {0x00000012,0x3E8,0x7} at start edge -> rx_data=0xA5, rx_stamp=0x000000123E87, flags 0, rx_valid one cycle.
REQ-035 Rx low 20 clk then high (BAUD_DIV=4) -> no rx_valid, FSM back to IDLE, next 0x3C received correctly.
REQ-036 Send 0x55 with stop bit forced low -> rx_data=0x55, frame_err=1.
REQ-037 PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1; with parity 1 -> parity_err=0.
REQ-038 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun single-cycle pulse at 0x22 completion; raise rx_ready -> rx_valid drops next cycle.
REQ-039 Assert rst during D4 of 0x81, release, send 0x42 -> only 0x42 delivered, all outputs 0 during reset.
